fifo_width_cdc: RTL and testbench
=================================

FIFO_WIDTH_CDC -- requirements
Module: fifo_width_cdc

Interface
REQ-001 SHALL have parameter DSIZE, default 8, read element width in bits.
REQ-002 SHALL have parameter NSIZE, default 4, elements per write word; legal 1,2,4,8,16.
REQ-003 SHALL have parameter ADDR_W, default 3, write-side depth DEPTH = 2^ADDR_W words.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = element 0 is wr_data[DSIZE*NSIZE-1 -: DSIZE], 0 = element 0 is wr_data[DSIZE-1:0].
REQ-005 SHALL have parameter FWFT, default 0; 1 = first-word-fall-through read mode.
REQ-006 SHALL have parameters AF_LVL (words, default DEPTH-1) and AE_LVL (elements, default 1).
REQ-007 SHALL have: wr_clk  in  1  write clock.
REQ-008 SHALL have: rst_n  in  1  reset, asynchronous, active-low, shared by both domains.
REQ-009 SHALL have: rd_clk  in  1  read clock, asynchronous to wr_clk.
REQ-010 SHALL have: wr_en  in  1  write request; wr_data  in  DSIZE*NSIZE  write word.
REQ-011 SHALL have: wr_full, wr_almost_full, wr_ovf  out  1 each; wr_count  out  ADDR_W+1  words occupied.
REQ-012 SHALL have: rd_en  in  1; rd_data  out  DSIZE; rd_vld, rd_empty, rd_almost_empty, rd_udf  out  1 each; rd_count  out  ADDR_W+log2(NSIZE)+1  elements available.

Function
REQ-013 SHALL keep binary write pointer wp (ADDR_W+1 bits, words) and read pointer rp (ADDR_W+S+1 bits, elements, S=log2 NSIZE), both wrapping modulo 2x capacity.
REQ-014 SHALL pass each pointer across domains as registered Gray code through two flops in the destination clock; no binary pointer bit crosses directly.
REQ-015 SHALL compute write-side occupancy wr_count = wp - (rp_sync >> S); a partially read word counts as occupied.
REQ-016 SHALL assert wr_full when wr_count == DEPTH and wr_almost_full when wr_count >= AF_LVL.
REQ-017 SHALL compute rd_count = (wp_sync << S) - rp; rd_empty when rd_count == 0 (non-FWFT); rd_almost_empty when rd_count <= AE_LVL.
REQ-018 SHALL accept a write when wr_en && !wr_full: store word, wp+1 at that wr_clk edge.
REQ-019 SHALL ignore wr_en while wr_full (memory and wp unchanged) and set sticky wr_ovf.
REQ-020 Non-FWFT: on rd_en && !rd_empty SHALL register next element onto rd_data, pulse rd_vld for exactly the following cycle, rp+1.
REQ-021 Non-FWFT: rd_data SHALL hold its last value when no read is accepted.
REQ-022 FWFT: head element SHALL be presented with rd_vld=1 without rd_en; rd_en while rd_vld pops it; rd_empty SHALL equal !rd_vld; next element (if any) valid on the following cycle.
REQ-023 SHALL ignore rd_en while empty (no rp change, no rd_vld) and set sticky rd_udf.
REQ-024 SHALL deliver elements strictly in write order, element 0..NSIZE-1 per word per MSB_FIRST.
REQ-025 Written word SHALL be visible on the read side (rd_empty falls) no later than 4 rd_clk edges after the accepting wr_clk edge; freed word SHALL clear wr_full no later than 4 wr_clk edges after the last element's read edge.
REQ-026 Simultaneous write and read SHALL both take effect; flags are conservative (never report space/data that does not exist).
REQ-027 NSIZE=1 SHALL behave as plain asynchronous FIFO of DSIZE bits.

Reset
REQ-028 rst_n low SHALL asynchronously clear wp, rp, Gray and synchroniser flops, wr_ovf, rd_udf, rd_vld, rd_data (to 0), wr_count, rd_count; wr_full=0, wr_almost_full=0, rd_empty=1, rd_almost_empty=1.
REQ-029 SHALL synchronise rst_n deassertion separately into each clock domain (two flops); memory contents need not be reset.
REQ-030 Reset asserted mid-transfer SHALL discard all stored data; first read after reset returns first word written after reset.

Verification (DSIZE=8, NSIZE=4, ADDR_W=2, unrelated clocks unless noted)
REQ-031 Write 0xA1B2C3D4, MSB_FIRST=1, non-FWFT -> four reads return 0xA1,0xB2,0xC3,0xD4 each with rd_vld one cycle later; rd_empty=1 afterwards.
REQ-032 Write 5 words without reads -> wr_full=1 after 4th, wr_count=4, 5th dropped, wr_ovf=1; reads return first 4 words only.
REQ-033 From full, read 1 element -> wr_full stays 1; after 4th element read, wr_full=0 within 4 wr_clk edges, wr_count=3.
REQ-034 rd_en on empty FIFO -> rd_vld=0, rp unchanged, rd_udf=1; FWFT=1 variant: single write produces rd_vld=1 with 0xA1 before any rd_en.
REQ-035 Continuous streaming 100 random words, wr_clk 100 MHz, rd_clk 370 MHz -> 400 elements in order, no ovf/udf, pointers wrap repeatedly.
REQ-036 Assert rst_n low for 1 wr_clk cycle mid-stream -> all outputs at REQ-028 values immediately; next written word 0x11223344 read back as 0x11,0x22,0x33,0x44.

Source files
------------

// File: rtl/fifo_width_cdc.sv
// Dual-clock FIFO with a width change: writes whole words of NSIZE elements,
// reads single DSIZE-bit elements. Pointers cross domains as Gray code.
module fifo_width_cdc #(
  parameter int DSIZE     = 8,
  parameter int NSIZE     = 4,
  parameter int ADDR_W    = 3,
  parameter int MSB_FIRST = 1,
  parameter int FWFT      = 0,
  parameter int AF_LVL    = (1 << ADDR_W) - 1,
  parameter int AE_LVL    = 1
) (
  input  logic                              wr_clk,
  input  logic                              rst_n,
  input  logic                              rd_clk,
  input  logic                              wr_en,
  input  logic [DSIZE*NSIZE-1:0]            wr_data,
  output logic                              wr_full,
  output logic                              wr_almost_full,
  output logic                              wr_ovf,
  output logic [ADDR_W:0]                   wr_count,
  input  logic                              rd_en,
  output logic [DSIZE-1:0]                  rd_data,
  output logic                              rd_vld,
  output logic                              rd_empty,
  output logic                              rd_almost_empty,
  output logic                              rd_udf,
  output logic [ADDR_W+$clog2(NSIZE):0]     rd_count
);

  localparam int S     = $clog2(NSIZE);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int WPW   = ADDR_W + 1;
  localparam int RPW   = ADDR_W + S + 1;
  localparam int WW    = DSIZE * NSIZE;

  logic [1:0]     r_wr_rst_sync;
  logic [1:0]     r_rd_rst_sync;
  logic           w_wr_rst_n;
  logic           w_rd_rst_n;

  logic [WW-1:0]  r_mem [DEPTH];

  logic [WPW-1:0] r_wp;
  logic [WPW-1:0] r_wp_gray;
  logic [WPW-1:0] w_wp_next;
  logic [RPW-1:0] r_rp_gray_s1;
  logic [RPW-1:0] r_rp_gray_s2;
  logic [RPW-1:0] w_rp_sync;
  logic           w_wr_acc;
  logic           r_wr_ovf;

  logic [RPW-1:0] r_rp;
  logic [RPW-1:0] r_rp_gray;
  logic [RPW-1:0] w_rp_next;
  logic [WPW-1:0] r_wp_gray_s1;
  logic [WPW-1:0] r_wp_gray_s2;
  logic [WPW-1:0] w_wp_sync;
  logic [RPW-1:0] w_rd_count;
  logic [WW-1:0]  w_word;
  logic [DSIZE-1:0] w_elem;
  logic           w_rd_load;
  logic           w_vld_next;
  logic           w_empty;
  logic           w_udf_set;
  logic [DSIZE-1:0] r_rd_data;
  logic           r_rd_vld;
  logic           r_rd_udf;

  // Reset asserts at once in both domains, releases two edges later in each.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) r_wr_rst_sync <= '0;
    else        r_wr_rst_sync <= {r_wr_rst_sync[0], 1'b1};
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) r_rd_rst_sync <= '0;
    else        r_rd_rst_sync <= {r_rd_rst_sync[0], 1'b1};
  end

  assign w_wr_rst_n = r_wr_rst_sync[1];
  assign w_rd_rst_n = r_rd_rst_sync[1];

  // ---------------- write domain ----------------
  assign w_wr_acc  = wr_en && !wr_full && w_wr_rst_n;
  assign w_wp_next = r_wp + WPW'(1);

  always_ff @(posedge wr_clk) begin
    if (w_wr_acc) r_mem[r_wp[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge wr_clk or negedge w_wr_rst_n) begin
    if (!w_wr_rst_n) begin
      r_wp         <= '0;
      r_wp_gray    <= '0;
      r_rp_gray_s1 <= '0;
      r_rp_gray_s2 <= '0;
      r_wr_ovf     <= 1'b0;
    end else begin
      r_rp_gray_s1 <= r_rp_gray;
      r_rp_gray_s2 <= r_rp_gray_s1;
      if (w_wr_acc) begin
        r_wp      <= w_wp_next;
        r_wp_gray <= w_wp_next ^ (w_wp_next >> 1);
      end
      if (wr_en && wr_full) r_wr_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_rp_sync = '0;
    for (int i = 0; i < RPW; i++) w_rp_sync[i] = ^(r_rp_gray_s2 >> i);
  end

  // A word whose elements are only partly consumed still occupies its slot.
  assign wr_count       = r_wp - WPW'(w_rp_sync >> S);
  assign wr_full        = (wr_count == WPW'(DEPTH));
  assign wr_almost_full = (wr_count >= WPW'(AF_LVL));
  assign wr_ovf         = r_wr_ovf;

  // ---------------- read domain ----------------
  always_comb begin
    w_wp_sync = '0;
    for (int i = 0; i < WPW; i++) w_wp_sync[i] = ^(r_wp_gray_s2 >> i);
  end

  assign w_rd_count = (RPW'(w_wp_sync) << S) - r_rp;
  assign w_rp_next  = r_rp + RPW'(1);
  assign w_word     = r_mem[r_rp[RPW-2:S]];

  always_comb begin
    int idx;
    int off;
    idx = int'(r_rp & RPW'(NSIZE - 1));
    if (MSB_FIRST != 0) off = (NSIZE - 1 - idx) * DSIZE;
    else                off = idx * DSIZE;
    w_elem = DSIZE'(w_word >> off);
  end

  // In FWFT mode the output register holds the head element; rp counts
  // elements already moved into it.
  always_comb begin
    if (FWFT != 0) begin
      w_rd_load  = (w_rd_count != '0) && (!r_rd_vld || rd_en);
      w_vld_next = w_rd_load || (r_rd_vld && !rd_en);
      w_empty    = !r_rd_vld;
    end else begin
      w_rd_load  = rd_en && (w_rd_count != '0);
      w_vld_next = w_rd_load;
      w_empty    = (w_rd_count == '0);
    end
    w_udf_set = rd_en && w_empty;
  end

  always_ff @(posedge rd_clk or negedge w_rd_rst_n) begin
    if (!w_rd_rst_n) begin
      r_rp         <= '0;
      r_rp_gray    <= '0;
      r_wp_gray_s1 <= '0;
      r_wp_gray_s2 <= '0;
      r_rd_data    <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_udf     <= 1'b0;
    end else begin
      r_wp_gray_s1 <= r_wp_gray;
      r_wp_gray_s2 <= r_wp_gray_s1;
      r_rd_vld     <= w_vld_next;
      if (w_rd_load) begin
        r_rd_data <= w_elem;
        r_rp      <= w_rp_next;
        r_rp_gray <= w_rp_next ^ (w_rp_next >> 1);
      end
      if (w_udf_set) r_rd_udf <= 1'b1;
    end
  end

  assign rd_data         = r_rd_data;
  assign rd_vld          = r_rd_vld;
  assign rd_empty        = w_empty;
  assign rd_almost_empty = (w_rd_count <= RPW'(AE_LVL));
  assign rd_udf          = r_rd_udf;
  assign rd_count        = w_rd_count;

endmodule

// File: tb/tb_fifo_width_cdc.sv
// Randomized and directed bench for fifo_width_cdc: an element queue model
// predicts every read, plus literal checks on known scenarios.
`timescale 1ns/10ps
module tb_fifo_width_cdc;
  localparam int NS = 4;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic rst_n  = 1'b1;

  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        wr_full, wr_almost_full, wr_ovf;
  logic [2:0]  wr_count;
  logic [7:0]  rd_data;
  logic        rd_vld, rd_empty, rd_almost_empty, rd_udf;
  logic [4:0]  rd_count;

  logic        wr_en_f = 1'b0;
  logic [31:0] wr_data_f = '0;
  logic        rd_en_f = 1'b0;
  logic        wr_full_f, wr_almost_full_f, wr_ovf_f;
  logic [2:0]  wr_count_f;
  logic [7:0]  rd_data_f;
  logic        rd_vld_f, rd_empty_f, rd_almost_empty_f, rd_udf_f;
  logic [4:0]  rd_count_f;

  always #5    wr_clk = ~wr_clk;
  always #1.35 rd_clk = ~rd_clk;

  fifo_width_cdc #(.DSIZE(8), .NSIZE(4), .ADDR_W(2), .MSB_FIRST(1), .FWFT(0)) u_dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .rd_clk(rd_clk),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_almost_full(wr_almost_full), .wr_ovf(wr_ovf), .wr_count(wr_count),
    .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .rd_udf(rd_udf), .rd_count(rd_count)
  );

  fifo_width_cdc #(.DSIZE(8), .NSIZE(4), .ADDR_W(2), .MSB_FIRST(1), .FWFT(1)) u_fwft (
    .wr_clk(wr_clk), .rst_n(rst_n), .rd_clk(rd_clk),
    .wr_en(wr_en_f), .wr_data(wr_data_f),
    .wr_full(wr_full_f), .wr_almost_full(wr_almost_full_f), .wr_ovf(wr_ovf_f), .wr_count(wr_count_f),
    .rd_en(rd_en_f), .rd_data(rd_data_f), .rd_vld(rd_vld_f), .rd_empty(rd_empty_f),
    .rd_almost_empty(rd_almost_empty_f), .rd_udf(rd_udf_f), .rd_count(rd_count_f)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [7:0] exp_q[$];
  logic [7:0] rd_log[$];
  int         wwords = 0;
  int         rd_acc = 0;
  bit         exp_vld = 1'b0;
  bit         exp_udf = 1'b0;
  bit         exp_ovf = 1'b0;
  logic [7:0] last_data = '0;
  logic [7:0] e_byte;
  bit         chk_en = 1'b0;
  int         rd_mode = 0;
  int         rd_budget = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_full"},  64'(wr_full), 64'(0));
    chk({tag, "_wr_af"},    64'(wr_almost_full), 64'(0));
    chk({tag, "_wr_ovf"},   64'(wr_ovf), 64'(0));
    chk({tag, "_wr_count"}, 64'(wr_count), 64'(0));
    chk({tag, "_rd_data"},  64'(rd_data), 64'(0));
    chk({tag, "_rd_vld"},   64'(rd_vld), 64'(0));
    chk({tag, "_rd_empty"}, 64'(rd_empty), 64'(1));
    chk({tag, "_rd_ae"},    64'(rd_almost_empty), 64'(1));
    chk({tag, "_rd_udf"},   64'(rd_udf), 64'(0));
    chk({tag, "_rd_count"}, 64'(rd_count), 64'(0));
    chk({tag, "_f_vld"},    64'(rd_vld_f), 64'(0));
    chk({tag, "_f_empty"},  64'(rd_empty_f), 64'(1));
  endtask

  task automatic reset_model();
    exp_q.delete();
    wwords    = 0;
    rd_acc    = 0;
    exp_vld   = 1'b0;
    exp_udf   = 1'b0;
    exp_ovf   = 1'b0;
    last_data = '0;
  endtask

  // One write-side cycle; polite writers only request when there is room.
  task automatic wr_cycle(input bit en, input bit polite, input logic [31:0] d, output bit acc);
    bit en_eff;
    @(negedge wr_clk);
    if (chk_en) begin
      chk("wr_ovf", 64'(wr_ovf), 64'(exp_ovf));
      chk("wr_count_lb", 64'(int'(wr_count) >= wwords - rd_acc / NS), 64'(1));
      chk("wr_count_ub", 64'(int'(wr_count) <= 4), 64'(1));
    end
    en_eff  = en && (!polite || !wr_full);
    acc     = en_eff && !wr_full;
    wr_en   = en_eff;
    wr_data = d;
    if (en_eff && wr_full) exp_ovf = 1'b1;
    if (acc) begin
      wwords++;
      for (int k = 0; k < NS; k++) exp_q.push_back(8'(d >> (8 * (NS - 1 - k))));
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (rd_log.size() < n && c < budget) begin
      @(negedge rd_clk);
      c++;
    end
    if (rd_log.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d elements, expected %0d within %0d rd cycles", name, rd_log.size(), n, budget);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge wr_clk);
    chk_en = 1'b0;
    wr_en  = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_vals(tag);
    rd_mode = 0;
    #9 rst_n = 1'b1;
    repeat (6) @(negedge wr_clk);
    reset_model();
    chk_en = 1'b1;
  endtask

  // Compare process for the read side, then the reader's next request.
  initial begin
    forever begin
      @(negedge rd_clk);
      if (chk_en) begin
        chk("rd_vld", 64'(rd_vld), 64'(exp_vld));
        if (exp_vld) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_extra: got element 0x%0h, expected none (model empty)", rd_data);
          end else begin
            e_byte = exp_q.pop_front();
            chk("rd_data", 64'(rd_data), 64'(e_byte));
          end
          rd_log.push_back(rd_data);
          last_data = rd_data;
        end else begin
          chk("rd_hold", 64'(rd_data), 64'(last_data));
        end
        chk("rd_udf", 64'(rd_udf), 64'(exp_udf));
        chk("rd_count_ub", 64'(int'(rd_count) <= wwords * NS - rd_acc), 64'(1));
      end
      case (rd_mode)
        1:       rd_en = !rd_empty && ($urandom_range(1, 0) == 1);
        2:       rd_en = !rd_empty;
        3:       rd_en = !rd_empty && (rd_budget > 0);
        4: begin rd_en = 1'b1; rd_mode = 0; end
        default: rd_en = 1'b0;
      endcase
      exp_vld = rd_en && !rd_empty;
      if (rd_en && rd_empty) exp_udf = 1'b1;
      if (exp_vld) begin
        rd_acc++;
        if (rd_budget > 0) rd_budget--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200 us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit         acc;
    int         c;
    int         i;
    logic [31:0] w;
    logic [7:0] fexp [4];
    fexp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    #20 rst_n = 1'b1;
    repeat (6) @(negedge wr_clk);
    reset_model();
    chk_en = 1'b1;

    // single word, MSB element first, with write-to-read latency
    rd_log.delete();
    wr_cycle(1'b1, 1'b0, 32'hA1B2C3D4, acc);
    @(posedge wr_clk);
    #0.5 wr_en = 1'b0;
    c = 0;
    while (rd_empty && c < 10) begin
      @(posedge rd_clk);
      c++;
      #0.1;
    end
    chk("wr2rd_latency_le4", 64'(c <= 4), 64'(1));
    rd_mode = 2;
    wait_log(4, 40, "single_word");
    rd_mode = 0;
    chk("sw_e0", 64'(rd_log[0]), 64'(8'hA1));
    chk("sw_e1", 64'(rd_log[1]), 64'(8'hB2));
    chk("sw_e2", 64'(rd_log[2]), 64'(8'hC3));
    chk("sw_e3", 64'(rd_log[3]), 64'(8'hD4));
    repeat (3) @(negedge rd_clk);
    chk("sw_empty_after", 64'(rd_empty), 64'(1));

    // fill to full, fifth word dropped
    rd_log.delete();
    for (int k = 0; k < 4; k++) begin
      w = 32'h10203040 + 32'(k) * 32'h01010101;
      wr_cycle(1'b1, 1'b0, w, acc);
    end
    wr_cycle(1'b1, 1'b0, 32'h14243444, acc);
    chk("fifth_dropped", 64'(acc), 64'(0));
    chk("full_after4", 64'(wr_full), 64'(1));
    chk("count_after4", 64'(wr_count), 64'(4));
    chk("af_after4", 64'(wr_almost_full), 64'(1));
    wr_cycle(1'b0, 1'b0, '0, acc);
    wr_cycle(1'b0, 1'b0, '0, acc);
    chk("ovf_sticky", 64'(wr_ovf), 64'(1));

    // one element does not free a word; the fourth does
    rd_budget = 1;
    rd_mode   = 3;
    wait_log(1, 40, "read_one");
    repeat (8) wr_cycle(1'b0, 1'b0, '0, acc);
    chk("full_after_1elem", 64'(wr_full), 64'(1));
    chk("count_after_1elem", 64'(wr_count), 64'(4));
    rd_budget = 3;
    wait_log(4, 40, "read_word");
    c = 0;
    while (wr_full && c < 8) begin
      @(posedge wr_clk);
      c++;
      #1;
    end
    chk("full_release_le4", 64'(c <= 4), 64'(1));
    chk("full_released", 64'(wr_full), 64'(0));
    chk("count_after_word", 64'(wr_count), 64'(3));
    chk("fill_e0", 64'(rd_log[0]), 64'(8'h10));
    chk("fill_e3", 64'(rd_log[3]), 64'(8'h40));
    rd_budget = 12;
    wait_log(16, 100, "drain");
    repeat (6) @(negedge rd_clk);
    rd_mode = 0;
    chk("drain_size", 64'(rd_log.size()), 64'(16));
    chk("fill_e4", 64'(rd_log[4]), 64'(8'h11));
    chk("fill_e15", 64'(rd_log[15]), 64'(8'h43));
    chk("drain_empty", 64'(rd_empty), 64'(1));
    chk("drain_ae", 64'(rd_almost_empty), 64'(1));

    // read while empty
    rd_mode = 4;
    repeat (4) @(negedge rd_clk);
    chk("udf_set", 64'(rd_udf), 64'(1));
    chk("udf_no_vld", 64'(rd_vld), 64'(0));
    chk("udf_count", 64'(rd_count), 64'(0));
    chk("udf_log_size", 64'(rd_log.size()), 64'(16));
    repeat (3) wr_cycle(1'b0, 1'b0, '0, acc);
    chk("empty_wr_count", 64'(wr_count), 64'(0));

    // streaming 100 random words against a fast reader
    do_reset("pre_stream");
    rd_log.delete();
    rd_mode = 2;
    i = 0;
    c = 0;
    while (i < 100 && c < 3000) begin
      wr_cycle(1'b1, 1'b1, $urandom, acc);
      if (acc) i++;
      c++;
    end
    wr_cycle(1'b0, 1'b0, '0, acc);
    chk("stream_words_written", 64'(i), 64'(100));
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(negedge rd_clk);
      c++;
    end
    repeat (4) @(negedge rd_clk);
    rd_mode = 0;
    chk("stream_elems", 64'(rd_log.size()), 64'(400));
    chk("stream_no_ovf", 64'(wr_ovf), 64'(0));
    chk("stream_no_udf", 64'(rd_udf), 64'(0));

    // reset in the middle of traffic
    rd_mode = 1;
    for (int k = 0; k < 12; k++) wr_cycle(1'b1, 1'b1, $urandom, acc);
    do_reset("mid");
    rd_log.delete();
    wr_cycle(1'b1, 1'b0, 32'h11223344, acc);
    wr_cycle(1'b0, 1'b0, '0, acc);
    rd_mode = 2;
    wait_log(4, 40, "after_reset");
    repeat (4) @(negedge rd_clk);
    rd_mode = 0;
    chk("rst_e0", 64'(rd_log[0]), 64'(8'h11));
    chk("rst_e1", 64'(rd_log[1]), 64'(8'h22));
    chk("rst_e2", 64'(rd_log[2]), 64'(8'h33));
    chk("rst_e3", 64'(rd_log[3]), 64'(8'h44));
    chk("rst_size", 64'(rd_log.size()), 64'(4));

    // first-word-fall-through variant
    @(negedge wr_clk);
    wr_en_f   = 1'b1;
    wr_data_f = 32'hA1B2C3D4;
    @(negedge wr_clk);
    wr_en_f = 1'b0;
    c = 0;
    while (!rd_vld_f && c < 12) begin
      @(negedge rd_clk);
      c++;
    end
    chk("fwft_vld", 64'(rd_vld_f), 64'(1));
    chk("fwft_head", 64'(rd_data_f), 64'(8'hA1));
    chk("fwft_not_empty", 64'(rd_empty_f), 64'(0));
    repeat (3) @(negedge rd_clk);
    for (int k = 0; k < 4; k++) begin
      chk("fwft_pop_vld", 64'(rd_vld_f), 64'(1));
      chk("fwft_pop_data", 64'(rd_data_f), 64'(fexp[k]));
      rd_en_f = 1'b1;
      @(negedge rd_clk);
    end
    rd_en_f = 1'b0;
    chk("fwft_drained_vld", 64'(rd_vld_f), 64'(0));
    chk("fwft_drained_empty", 64'(rd_empty_f), 64'(1));
    chk("fwft_no_udf", 64'(rd_udf_f), 64'(0));
    rd_en_f = 1'b1;
    @(negedge rd_clk);
    rd_en_f = 1'b0;
    @(negedge rd_clk);
    chk("fwft_udf", 64'(rd_udf_f), 64'(1));
    chk("fwft_udf_no_vld", 64'(rd_vld_f), 64'(0));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
